// File: rtl/res_collector_pkg.sv
// res_collector_pkg: shared types and widths for the result collector.
//   bank_state_e : per-bank occupancy state (empty / filling / full)
//   DROP_CNT_W   : width of the saturating overrun counter
//   BATCH_CNT_W  : width of the wrapping completed-batch counter
//   CSUM_W       : width of the optional per-bank modular checksum
package res_collector_pkg;

  typedef enum logic [1:0] {
    StEmpty   = 2'd0,
    StFilling = 2'd1,
    StFull    = 2'd2
  } bank_state_e;

  localparam int unsigned DROP_CNT_W  = 16;
  localparam int unsigned BATCH_CNT_W = 32;
  localparam int unsigned CSUM_W      = 16;

  // Index width for NUM items; at least one bit so NUM=1 still elaborates.
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/res_bank.sv
// res_bank: one ping-pong bank of the result collector.
// Holds NUM items plus an occupancy state. Optional checksum when
// RES_COLLECTOR_CSUM_EN is defined.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   wr_en_i        : store wr_data_i at wr_idx_i (caller guarantees bank not full)
//   wr_idx_i       : item index; writing index NUM-1 makes the bank full
//   wr_data_i      : item data
//   free_i         : batch consumed, bank returns to empty (only asserted when full)
//   state_o        : current bank state
//   data_o         : flat item storage, item k at [k*ITEM_WIDTH +: ITEM_WIDTH]
//   csum_o         : modular sum of stored items (RES_COLLECTOR_CSUM_EN only)
module res_bank
  import res_collector_pkg::*;
#(
  parameter int unsigned NUM        = 100,
  parameter int unsigned ITEM_WIDTH = 8,
  parameter int unsigned IDX_W      = idx_width(NUM)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      wr_en_i,
  input  logic [IDX_W-1:0]          wr_idx_i,
  input  logic [ITEM_WIDTH-1:0]     wr_data_i,
  input  logic                      free_i,
  output bank_state_e               state_o,
`ifdef RES_COLLECTOR_CSUM_EN
  output logic [CSUM_W-1:0]         csum_o,
`endif
  output logic [NUM*ITEM_WIDTH-1:0] data_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM - 1);

  bank_state_e              state_q, state_d;
  logic [NUM*ITEM_WIDTH-1:0] data_q;

  always_comb begin
    state_d = state_q;
    if (free_i) begin
      state_d = StEmpty;
    end else if (wr_en_i) begin
      state_d = (wr_idx_i == LastIdx) ? StFull : StFilling;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage needs no reset: contents are only observed while the bank is full.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[int'(wr_idx_i)*ITEM_WIDTH +: ITEM_WIDTH] <= wr_data_i;
    end
  end

  assign state_o = state_q;
  assign data_o  = data_q;

`ifdef RES_COLLECTOR_CSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (free_i) begin
      csum_d = '0;
    end else if (wr_en_i) begin
      csum_d = csum_q + CSUM_W'(wr_data_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;
`endif

endmodule

// File: rtl/res_collector.sv
// res_collector: packs NUM consecutive valid results into a batch word using two
// ping-pong banks and presents full batches with a valid/ready handshake.
// The producer is never back-pressured; items arriving while the write bank is
// still full are dropped and counted.
// Optional macro RES_COLLECTOR_CSUM_EN adds a per-batch 16-bit checksum output.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   res_i          : result item
//   res_valid_i    : res_i valid this cycle
//   batch_o        : presented batch (0 while not valid), item 0 in the LSBs
//   batch_valid_o  : a full batch is presented
//   batch_ready_i  : consumer accepts the presented batch
//   batch_cnt_o    : batches completed since reset (wraps)
//   drop_cnt_o     : items dropped for overrun (saturates)
//   batch_csum_o   : presented batch checksum (RES_COLLECTOR_CSUM_EN only)
module res_collector
  import res_collector_pkg::*;
#(
  parameter int unsigned NUM        = 100,
  parameter int unsigned ITEM_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [ITEM_WIDTH-1:0]     res_i,
  input  logic                      res_valid_i,
  output logic [NUM*ITEM_WIDTH-1:0] batch_o,
  output logic                      batch_valid_o,
  input  logic                      batch_ready_i,
  output logic [BATCH_CNT_W-1:0]    batch_cnt_o,
`ifdef RES_COLLECTOR_CSUM_EN
  output logic [CSUM_W-1:0]         batch_csum_o,
`endif
  output logic [DROP_CNT_W-1:0]     drop_cnt_o
);

  localparam int unsigned IdxW = idx_width(NUM);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM - 1);

  logic                   wsel_q, wsel_d;
  logic                   rsel_q, rsel_d;
  logic [IdxW-1:0]        widx_q, widx_d;
  logic [BATCH_CNT_W-1:0] batch_cnt_q, batch_cnt_d;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  bank_state_e               bank_state [2];
  logic [NUM*ITEM_WIDTH-1:0] bank_data  [2];
  logic [1:0]                bank_wr_en;
  logic [1:0]                bank_free;

  logic accept, drop, last, xfer;

  always_comb begin
    // Item in the reset cycle is ignored, so gate everything with reset.
    accept = res_valid_i && !reset_i && (bank_state[wsel_q] != StFull);
    drop   = res_valid_i && !reset_i && (bank_state[wsel_q] == StFull);
    last   = accept && (widx_q == LastIdx);
    xfer   = batch_valid_o && batch_ready_i && !reset_i;

    bank_wr_en         = 2'b00;
    bank_wr_en[wsel_q] = accept;
    bank_free          = 2'b00;
    bank_free[rsel_q]  = xfer;

    widx_d      = widx_q;
    wsel_d      = wsel_q;
    rsel_d      = rsel_q;
    batch_cnt_d = batch_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    if (accept) begin
      widx_d = last ? '0 : widx_q + IdxW'(1);
    end
    if (last) begin
      wsel_d      = ~wsel_q;
      batch_cnt_d = batch_cnt_q + BATCH_CNT_W'(1);
    end
    if (xfer) begin
      rsel_d = ~rsel_q;
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      widx_q      <= '0;
      batch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      widx_q      <= widx_d;
      batch_cnt_q <= batch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef RES_COLLECTOR_CSUM_EN
  logic [CSUM_W-1:0] bank_csum [2];
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    res_bank #(
      .NUM        (NUM),
      .ITEM_WIDTH (ITEM_WIDTH),
      .IDX_W      (IdxW)
    ) u_bank (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_en_i   (bank_wr_en[b]),
      .wr_idx_i  (widx_q),
      .wr_data_i (res_i),
      .free_i    (bank_free[b]),
      .state_o   (bank_state[b]),
`ifdef RES_COLLECTOR_CSUM_EN
      .csum_o    (bank_csum[b]),
`endif
      .data_o    (bank_data[b])
    );
  end

  always_comb begin
    batch_valid_o = (bank_state[rsel_q] == StFull);
    batch_o       = batch_valid_o ? bank_data[rsel_q] : '0;
  end

`ifdef RES_COLLECTOR_CSUM_EN
  assign batch_csum_o = batch_valid_o ? bank_csum[rsel_q] : '0;
`endif

  assign batch_cnt_o = batch_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
